temp_entry: RTL

//  Front-end digit-entry stage of the temperature monitor. Debounces the raw ENTER

---
 rtl/temp_entry_pkg.sv | 24 ++
 rtl/temp_entry_if.sv | 12 +
 rtl/temp_entry_key_debounce.sv | 55 +++++
 rtl/temp_entry.sv | 134 +++++++++++++
 4 files changed

// File: rtl/temp_entry_pkg.sv
// Shared definitions for the temperature monitor front end.
// Contains the entry FSM encoding, BCD limits and temperature band thresholds.
package temp_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIG_TENTHS = 2'd1,
        DIG_ONES   = 2'd2,
        DIG_TENS   = 2'd3
    } entry_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int unsigned TEMP_W = 12;

    // Band thresholds in BCD {tens, ones, tenths}, also used by the monitor stage
    localparam logic [TEMP_W-1:0] TEMP_COLD_BCD = 12'h050;
    localparam logic [TEMP_W-1:0] TEMP_WARM_BCD = 12'h300;
    localparam logic [TEMP_W-1:0] TEMP_HOT_BCD  = 12'h400;

    function automatic logic bcd_ok(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/temp_entry_if.sv
// Reading hand-off from the entry stage to the monitor/alarm stage.
// The master drives a committed BCD reading plus a one-cycle valid pulse.
interface temp_entry_if;
    import temp_pkg::*;

    logic [TEMP_W-1:0] temp_bcd;
    logic              temp_valid;

    modport master (output temp_bcd, output temp_valid);
    modport slave  (input  temp_bcd, input  temp_valid);

endinterface

// File: rtl/temp_entry_key_debounce.sv
// Synchroniser, debouncer and press detector for one active-low push button.
// After reset the key must first be seen released for a full debounce window before presses count.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [1:0]    sync;
    logic          armed;
    logic          target;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    // Until armed, the counter qualifies a stable release instead of a level change
    assign target = armed ? ~level : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] != target) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (armed) begin
                    level <= ~level;
                    press <= level;
                end else begin
                    armed <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/temp_entry.sv
// Digit-entry stage: collects tenths, ones and tens BCD digits on debounced ENTER presses
// and commits the assembled reading to the monitor with a one-cycle valid pulse.
module temp_entry
    import temp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 0
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              key_enter_n,
    input  logic [3:0]        sw_digit,
    temp_entry_if.master      reading,
    output logic [TEMP_W-1:0] entry_bcd,
    output logic [1:0]        input_state,
    output logic [2:0]        digit_en,
    output logic              digit_err
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    entry_state_t      state, state_nx;
    logic [TEMP_W-1:0] entry_nx;
    logic [TEMP_W-1:0] temp_q, temp_nx;
    logic              valid_q, valid_nx;
    logic              err_nx;
    logic [TW-1:0]     to_cnt;
    logic              timeout;
    logic              press;
    logic              key_level_unused;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .press (press),
        .level (key_level_unused)
    );

    assign timeout = TO_EN && (state != IDLE) && (to_cnt == TO_LAST);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (press || (state == IDLE) || timeout) begin
            to_cnt <= '0;
        end else if (TO_EN) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            entry_bcd <= '0;
            temp_q    <= '0;
            valid_q   <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            state     <= state_nx;
            entry_bcd <= entry_nx;
            temp_q    <= temp_nx;
            valid_q   <= valid_nx;
            digit_err <= err_nx;
        end
    end

    // A press in the same cycle as the timeout takes priority
    always_comb begin
        state_nx = state;
        entry_nx = entry_bcd;
        temp_nx  = temp_q;
        valid_nx = 1'b0;
        err_nx   = digit_err;
        if (press) begin
            unique case (state)
                IDLE: begin
                    state_nx = DIG_TENTHS;
                    entry_nx = '0;
                    err_nx   = 1'b0;
                end
                DIG_TENTHS: begin
                    if (bcd_ok(sw_digit)) begin
                        entry_nx[3:0] = sw_digit;
                        err_nx        = 1'b0;
                        state_nx      = DIG_ONES;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                DIG_ONES: begin
                    if (bcd_ok(sw_digit)) begin
                        entry_nx[7:4] = sw_digit;
                        err_nx        = 1'b0;
                        state_nx      = DIG_TENS;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                DIG_TENS: begin
                    if (bcd_ok(sw_digit)) begin
                        entry_nx[11:8] = sw_digit;
                        temp_nx        = {sw_digit, entry_bcd[7:0]};
                        valid_nx       = 1'b1;
                        err_nx         = 1'b0;
                        state_nx       = IDLE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
            entry_nx = '0;
            err_nx   = 1'b0;
        end
    end

    always_comb begin
        digit_en = 3'b000;
        unique case (state)
            IDLE:       digit_en = 3'b000;
            DIG_TENTHS: digit_en = 3'b001;
            DIG_ONES:   digit_en = 3'b010;
            DIG_TENS:   digit_en = 3'b100;
        endcase
    end

    assign input_state        = state;
    assign reading.temp_bcd   = temp_q;
    assign reading.temp_valid = valid_q;

endmodule
